// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous double buffering.
// Optional: define SEVEN_SEG_LZ_SUPPRESS_EN to darken leading-zero digits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_CYCLES     = 1024,
  parameter int BLANK_CYCLES     = 16,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic                    i_load,
  input  logic                    i_blank,
  output logic [6:0]              o_segout,
  output logic                    o_dp_out,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);
  localparam int CMAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  typedef logic [NUM_DIGITS-1:0][3:0] nib_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h67;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  nib_t                  r_disp, r_shadow, w_disp_nxt, w_shadow_nxt;
  logic [NUM_DIGITS-1:0] r_dpd, r_sdp, w_dpd_nxt, w_sdp_nxt;
  logic                  r_pend, w_pend_nxt;
  logic                  w_boundary, w_lit;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_onehot, w_lz, w_den_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic                  r_dpo, w_dpo_nxt, r_fd;
  logic [NUM_DIGITS-1:0] r_den;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_boundary   = 1'b0;
    case (r_state)
      ST_BLANK: if (BLANK_CYCLES == 0 || r_cnt == BLK_LAST) begin
        w_state_nxt = ST_SHOW;
        w_cnt_nxt   = '0;
      end
      ST_SHOW: if (r_cnt == DIG_LAST) begin
        w_cnt_nxt = '0;
        if (r_idx == IDX_LAST) begin
          w_idx_nxt  = '0;
          w_boundary = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
        if (BLANK_CYCLES != 0) w_state_nxt = ST_BLANK;
      end
      default: w_state_nxt = ST_BLANK;
    endcase

    // A load landing on the boundary edge bypasses the shadow and is shown at once.
    w_shadow_nxt = r_shadow;
    w_sdp_nxt    = r_sdp;
    w_pend_nxt   = r_pend;
    w_disp_nxt   = r_disp;
    w_dpd_nxt    = r_dpd;
    if (i_load) begin
      w_shadow_nxt = i_value_in;
      w_sdp_nxt    = i_dp_in;
      w_pend_nxt   = 1'b1;
    end
    if (w_boundary) begin
      if (i_load || r_pend) begin
        w_disp_nxt = w_shadow_nxt;
        w_dpd_nxt  = w_sdp_nxt;
      end
      w_pend_nxt = 1'b0;
    end

    // Outputs are decoded from next-state so they change on the same edge as the scan.
    w_lit               = (w_state_nxt == ST_SHOW) && !i_blank;
    w_nib               = w_disp_nxt[w_idx_nxt];
    w_onehot            = '0;
    w_onehot[w_idx_nxt] = w_lit;
    w_seg_nxt           = (w_lit && !w_lz[w_idx_nxt]) ? ~glyph(w_nib) : 7'h7F;
    w_dpo_nxt           = w_lit ? ~w_dpd_nxt[w_idx_nxt] : 1'b1;
    w_den_nxt           = DIGIT_ACTIVE_LOW ? ~w_onehot : w_onehot;
  end

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
  always_comb begin
    logic z;
    z    = 1'b1;
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z       = z && (w_disp_nxt[i] == 4'h0);
      w_lz[i] = z && !w_dpd_nxt[i];
    end
  end
`else
  assign w_lz = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_BLANK;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_disp   <= '0;
      r_dpd    <= '0;
      r_shadow <= '0;
      r_sdp    <= '0;
      r_pend   <= 1'b0;
      r_seg    <= 7'h7F;
      r_dpo    <= 1'b1;
      r_den    <= {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
      r_fd     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_disp   <= w_disp_nxt;
      r_dpd    <= w_dpd_nxt;
      r_shadow <= w_shadow_nxt;
      r_sdp    <= w_sdp_nxt;
      r_pend   <= w_pend_nxt;
      r_seg    <= w_seg_nxt;
      r_dpo    <= w_dpo_nxt;
      r_den    <= w_den_nxt;
      r_fd     <= w_boundary;
    end
  end

  assign o_segout     = r_seg;
  assign o_dp_out     = r_dpo;
  assign o_digit_en   = r_den;
  assign o_frame_done = r_fd;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: glyph table, directed scan/buffer corner cases,
// and randomized traffic checked every cycle against a slot-arithmetic display model.
module tb_seven_seg_scan_driver;
  localparam int ND    = 4;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n, load, blank;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [6:0]  segout;
  logic        dp_out, frame_done;
  logic [3:0]  digit_en;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value_in(value_in), .i_dp_in(dp_in),
    .i_load(load), .i_blank(blank), .o_segout(segout), .o_dp_out(dp_out),
    .o_digit_en(digit_en), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  // Model: k = edges since reset release; slot position in the frame follows by arithmetic.
  int          k = 0;
  logic [15:0] m_disp = '0, m_sh = '0;
  logic [3:0]  m_dp = '0, m_shdp = '0;
  logic        m_pend = 1'b0, m_blank = 1'b0;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit bnd;
    if (!rst_n) begin
      k = 0; m_disp = '0; m_dp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
    end else begin
      k++;
      bnd = (k % FRAME) == 0;
      if (load) begin m_sh = value_in; m_shdp = dp_in; end
      if (bnd) begin
        if (load || m_pend) begin m_disp = m_sh; m_dp = m_shdp; end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
    end
    m_blank = blank;
  endtask

  function automatic logic [12:0] model_exp();
    int s, d;
    logic lit, lz;
    logic [15:0] hi;
    logic [3:0] oh;
    logic [6:0] seg;
    s   = k % FRAME;
    d   = s / SLOT;
    lit = ((s % SLOT) >= BC) && !m_blank;
    hi  = m_disp >> (4 * d);
    lz  = 1'b0;
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    lz  = (d > 0) && (hi == 16'h0) && !m_dp[d];
`endif
    oh  = 4'b0001 << d;
    seg = (lit && !lz) ? ~GLYPH[hi[3:0]] : 7'h7F;
    return {seg, lit ? ~m_dp[d] : 1'b1, lit ? ~oh : 4'hF, (k > 0 && s == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("scan", 32'({segout, dp_out, digit_en, frame_done}), 32'(model_exp()));
  endtask

  task automatic wait_en(input logic [3:0] en, input string name);
    int n;
    n = 0;
    while (digit_en !== en && n < 3 * FRAME) begin tick(); n++; end
    check(name, 32'(digit_en), 32'(en));
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 3 * FRAME) begin tick(); n++; end
    check(name, 32'(frame_done), 32'(1));
  endtask

  task automatic wait_slot(input int s);
    for (int n = 0; n < 2 * FRAME && (k % FRAME) != s; n++) tick();
  endtask

  task automatic fd_period(input string name);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 3 * FRAME) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (frame_done !== 1'b1 && n < 3 * FRAME);
    check(name, 32'(n), 32'(FRAME));
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_seg"}, 32'(segout), 32'h7F);
    check({name, "_dp"},  32'(dp_out), 32'h1);
    check({name, "_en"},  32'(digit_en), 32'hF);
    check({name, "_fd"},  32'(frame_done), 32'h0);
  endtask

  initial begin
    logic [3:0] t;
    int n;
    tbl[0] = '{val: 16'h12AF, dp: 4'h0, seg: {7'h79, 7'h24, 7'h08, 7'h0E}, dpo: 4'hF};
    tbl[1] = '{val: 16'h3210, dp: 4'h5, seg: {7'h30, 7'h24, 7'h79, 7'h40}, dpo: 4'hA};
    tbl[2] = '{val: 16'h7654, dp: 4'h0, seg: {7'h78, 7'h02, 7'h12, 7'h19}, dpo: 4'hF};
    tbl[3] = '{val: 16'hBA98, dp: 4'hF, seg: {7'h03, 7'h08, 7'h18, 7'h00}, dpo: 4'h0};
    tbl[4] = '{val: 16'hFEDC, dp: 4'h0, seg: {7'h0E, 7'h06, 7'h21, 7'h46}, dpo: 4'hF};
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    tbl[5] = '{val: 16'h0050, dp: 4'h8, seg: {7'h40, 7'h7F, 7'h12, 7'h40}, dpo: 4'h7};
    tbl[6] = '{val: 16'h0050, dp: 4'h0, seg: {7'h7F, 7'h7F, 7'h12, 7'h40}, dpo: 4'hF};
`else
    tbl[5] = '{val: 16'h0050, dp: 4'h8, seg: {7'h40, 7'h40, 7'h12, 7'h40}, dpo: 4'h7};
    tbl[6] = '{val: 16'h0050, dp: 4'h0, seg: {7'h40, 7'h40, 7'h12, 7'h40}, dpo: 4'hF};
`endif

    rst_n = 1'b0; load = 1'b0; blank = 1'b0; value_in = '0; dp_in = '0;
    repeat (3) tick();
    check_reset_outs("reset");
    rst_n = 1'b1;
    n = 0;
    while (digit_en !== 4'hE && n < 50) begin tick(); n++; end
    check("first_lit_latency", 32'(n), 32'(BC));

    // Glyph / dp table: each entry becomes visible after the next frame boundary.
    for (int i = 0; i < 7; i++) begin
      value_in = tbl[i].val; dp_in = tbl[i].dp; load = 1'b1;
      tick();
      load = 1'b0;
      wait_fd($sformatf("tbl%0d_fd", i));
      for (int d = 0; d < ND; d++) begin
        t = 4'b0001 << d;
        wait_en(~t, $sformatf("tbl%0d_en%0d", i, d));
        check($sformatf("tbl%0d_seg%0d", i, d), 32'(segout), 32'(tbl[i].seg[d]));
        check($sformatf("tbl%0d_dp%0d", i, d), 32'(dp_out), 32'(tbl[i].dpo[d]));
      end
    end
    dp_in = '0;
    fd_period("frame_period");

    // Mid-frame load must not tear the frame on display.
    value_in = 16'h12AF; load = 1'b1; tick(); load = 1'b0;
    wait_fd("tear_fd0");
    wait_en(4'hD, "tear_en1");
    value_in = 16'h0000; load = 1'b1; tick(); load = 1'b0;
    wait_en(4'h7, "tear_en3");
    check("tear_old_d3", 32'(segout), 32'h79);
    wait_fd("tear_fd1");
    wait_en(4'hE, "tear_en0");
    check("tear_new_d0", 32'(segout), 32'h40);

    // Load coincident with the boundary edge shows in the very next frame.
    wait_slot(FRAME - 1);
    value_in = 16'h7654; load = 1'b1; tick(); load = 1'b0;
    check("bnd_fd", 32'(frame_done), 32'h1);
    wait_en(4'hE, "bnd_en0");
    check("bnd_load_d0", 32'(segout), 32'h19);

    // Blank: dark while high, scan timing untouched, release visible next cycle.
    wait_slot(5);
    blank = 1'b1;
    repeat (20) tick();
    check("blank_en", 32'(digit_en), 32'hF);
    check("blank_seg", 32'(segout), 32'h7F);
    blank = 1'b0;
    tick();
    check("blank_release", 32'(digit_en), 32'hB);
    blank = 1'b1;
    fd_period("blank_fd_period");
    blank = 1'b0;

    // Reset in the middle of digit 2.
    wait_slot(25);
    rst_n = 1'b0; tick();
    check_reset_outs("mid_reset");
    rst_n = 1'b1;
    wait_fd("mid_reset_fd");
    wait_en(4'hE, "mid_reset_en0");
    check("mid_reset_d0_zero", 32'(segout), 32'h40);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      load     = ($urandom_range(0, 7) == 0);
      value_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank = ~blank;
      rst_n    = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1; load = 1'b0; blank = 1'b0;
    fd_period("final_frame_period");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-cathode/anode seven-segment digits sharing one active-low segment bus.
- Scans one digit at a time with a blanking gap between digits to avoid ghosting.
- Double-buffers the displayed hex value so updates land only on frame boundaries (no tearing).
- Sits between the glitcher control/status logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- DIGIT_CYCLES, 1024, clocks each digit is lit per frame; must be >= 1.
- BLANK_CYCLES, 16, clocks of all-off gap before each digit; 0 removes the gap.
- DIGIT_ACTIVE_LOW, 1, 1 = digit_en active-low, 0 = active-high.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- value_in  input  4*NUM_DIGITS  hex value; nibble i (bits 4i+3:4i) shown on digit i, digit 0 least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
- load  input  1  one-cycle strobe; captures value_in/dp_in into the shadow register.
- blank  input  1  level; when high all digits dark, scan keeps running.
- segout  output  7  segments gfedcba (bit0 = a), active-low, registered.
- dp_out  output  1  decimal point segment, active-low, registered.
- digit_en  output  NUM_DIGITS  one-hot digit select, polarity per DIGIT_ACTIVE_LOW, registered.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State BLANK, digit index 0, cycle counter 0.
  - Shadow/display value and dp registers 0, pending flag 0.
  - segout = 7'h7F, dp_out = 1, digit_en all inactive, frame_done = 0.
  - Reset asserted mid-scan takes effect at the next edge, overriding everything.
- Glyphs, active-high gfedcba before inversion:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=67 A=77 B=7C C=39 D=5E E=79 F=71
  - segout is the bitwise inverse.
- FSM:
  - BLANK: BLANK_CYCLES clocks, all digits inactive, segout 7F, dp_out 1; then go to SHOW.
  - SHOW: DIGIT_CYCLES clocks; digit_en asserts bit [index] only; segout = glyph(display nibble[index]); dp_out = ~display_dp[index].
  - Leaving SHOW: index increments; from NUM_DIGITS-1 it wraps to 0 and this is the frame boundary.
  - If BLANK_CYCLES = 0: BLANK is never entered; SHOW follows SHOW directly.
  - If NUM_DIGITS = 1: index stays 0.
- Frame and output timing:
  - Frame length = NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) clocks.
  - Outputs are registered and change on the edge the state/index changes.
  - After reset release: first lit digit 0 appears BLANK_CYCLES clocks later.
- Counter: $clog2 of max(DIGIT_CYCLES, BLANK_CYCLES, 2) bits; counts 0..N-1 and clears on state change.
- Double buffer:
  - load sets shadow <= inputs and pending <= 1.
  - At a frame boundary with pending = 1: display <= shadow, pending <= 0.
  - frame_done pulses on the boundary edge whether or not a transfer occurred.
  - load coincident with the boundary: the newly loaded value goes straight to display and pending ends 0 (load wins).
  - Multiple loads within one frame: last one wins.
- blank high in SHOW: digit_en inactive, segout 7F, dp_out 1. Counters, index and buffering are unaffected. Release takes effect the next cycle.

Optional Feature:
- Macro: SEVEN_SEG_LZ_SUPPRESS_EN.
- Defined: digit i > 0 shows segout 7F (digit_en still asserted) when its display nibble and all higher nibbles are 0 and display_dp[i] = 0. Digit 0 is always shown, so value 0 displays "0".
- Undefined: every digit shows its glyph, leading zeros included.

Test Plan:
- Reset: hold rst_n low 3 clocks -> segout 7F, dp_out 1, digit_en 4'hF (active-low), frame_done 0; first digit_en 4'hE exactly BLANK_CYCLES clocks after release.
- NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, load 16'h12AF -> after next frame boundary: digit0 segout ~71, digit1 ~77, digit2 ~5B, digit3 ~06; each digit lit 8 clocks, 2-clock gaps; frame_done period 40 clocks.
- Tearing: load 16'h0000 mid-frame while 16'h12AF is shown -> remaining digits of the current frame still show 12AF; 0000 appears only after frame_done; load on the boundary cycle -> new value in the very next frame.
- blank high for 20 clocks -> digit_en all inactive, segout 7F; frame_done spacing stays 40 clocks; display resumes the next cycle after release.
- Reset mid-SHOW of digit 2 -> next edge returns to reset state; display reads 0 after the first boundary unless load is asserted.
- SEVEN_SEG_LZ_SUPPRESS_EN defined, value 16'h0050, dp_in 0 -> digits 3,2 dark, digit1 ~6D, digit0 ~3F; with dp_in[3]=1 -> digit 3 shows ~3F with dp_out 0.
